// File: rtl/mouse_device_sm.sv
// PS/2 mouse device-side protocol FSM: host command decode, response/packet byte queue, BAT delay.
// Optional: define MOUSE_DEV_RESEND_EN to answer host FE by repeating the last byte sent.
module mouse_device_sm #(
    parameter logic [23:0] BAT_DELAY = 24'd1000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BYTE_READY,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    output logic       READ_ENABLE,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    input  logic [7:0] MOVE_STATUS,
    input  logic [7:0] MOVE_DX,
    input  logic [7:0] MOVE_DY,
    input  logic       MOVE_VALID,
    output logic       MOVE_READY,
    output logic       STREAM_EN
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_WAIT  = 2'd2;
    localparam logic [1:0] BAT_WAIT = 2'd3;

    logic [1:0]  state;
    logic [7:0]  q [3];
    logic [1:0]  q_cnt;
    logic [23:0] bat_cnt;
    logic        bat_pending;

    logic [7:0]  rsp_b [3];
    logic [1:0]  rsp_n;
    logic        stream_set;
    logic        stream_clr;
    logic        bat_start;
    logic        host_take;
    logic        move_take;

`ifdef MOUSE_DEV_RESEND_EN
    logic [7:0]  last_sent;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_sent <= 8'h00;
        end else if (BYTE_SENT) begin
            last_sent <= BYTE_TO_SEND;
        end
    end
`endif

    // The receiver is only listening while no byte is in flight.
    assign READ_ENABLE = (state == IDLE) || (state == BAT_WAIT);
    assign MOVE_READY  = (state == IDLE) && STREAM_EN && !BYTE_READY;
    assign host_take   = BYTE_READY && READ_ENABLE;
    assign move_take   = MOVE_VALID && MOVE_READY;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        rsp_b[0]   = 8'hFA;
        rsp_b[1]   = 8'h00;
        rsp_b[2]   = 8'h00;
        rsp_n      = 2'd1;
        stream_set = 1'b0;
        stream_clr = 1'b0;
        bat_start  = 1'b0;
        if (BYTE_ERROR_CODE != 2'b00) begin
            rsp_b[0] = 8'hFE;
        end else begin
            case (BYTE_READ)
                8'hFF: begin
                    stream_clr = 1'b1;
                    bat_start  = 1'b1;
                end
                8'hF4: stream_set = 1'b1;
                8'hF5: stream_clr = 1'b1;
                8'hF2: rsp_n = 2'd2;
`ifdef MOUSE_DEV_RESEND_EN
                8'hFE: rsp_b[0] = last_sent;
`endif
                default: ;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments only; the small byte queue is
    // reset too, so a reset mid-transfer leaves nothing stale behind.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            q[0]         <= 8'h00;
            q[1]         <= 8'h00;
            q[2]         <= 8'h00;
            q_cnt        <= 2'd0;
            bat_cnt      <= 24'd0;
            bat_pending  <= 1'b0;
            SEND_BYTE    <= 1'b0;
            BYTE_TO_SEND <= 8'h00;
            STREAM_EN    <= 1'b0;
        end else begin
            SEND_BYTE <= 1'b0;
            case (state)
                IDLE, BAT_WAIT: begin
                    if (host_take) begin
                        q[0]        <= rsp_b[0];
                        q[1]        <= rsp_b[1];
                        q[2]        <= rsp_b[2];
                        q_cnt       <= rsp_n;
                        bat_pending <= bat_start;
                        bat_cnt     <= 24'd0;
                        if (stream_set) STREAM_EN <= 1'b1;
                        if (stream_clr) STREAM_EN <= 1'b0;
                        state       <= TX_START;
                    end else if (move_take) begin
                        q[0]  <= MOVE_STATUS | 8'h08;
                        q[1]  <= MOVE_DX;
                        q[2]  <= MOVE_DY;
                        q_cnt <= 2'd3;
                        state <= TX_START;
                    end else if (state == BAT_WAIT) begin
                        if (bat_cnt == BAT_DELAY - 24'd1) begin
                            q[0]        <= 8'hAA;
                            q[1]        <= 8'h00;
                            q_cnt       <= 2'd2;
                            bat_pending <= 1'b0;
                            state       <= TX_START;
                        end else begin
                            bat_cnt <= bat_cnt + 24'd1;
                        end
                    end
                end
                TX_START: begin
                    SEND_BYTE    <= 1'b1;
                    BYTE_TO_SEND <= q[0];
                    state        <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (BYTE_SENT) begin
                        q[0]  <= q[1];
                        q[1]  <= q[2];
                        q[2]  <= 8'h00;
                        q_cnt <= q_cnt - 2'd1;
                        if (q_cnt > 2'd1) begin
                            state <= TX_START;
                        end else if (bat_pending) begin
                            bat_cnt <= 24'd0;
                            state   <= BAT_WAIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mouse_device_sm.sv
// Self-checking bench for mouse_device_sm: command table plus hand-written BAT, packet and reset sequences.
module tb_mouse_device_sm;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       BYTE_READY = 1'b0;
    logic [7:0] BYTE_READ = 8'h00;
    logic [1:0] BYTE_ERROR_CODE = 2'b00;
    logic       READ_ENABLE;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT = 1'b0;
    logic [7:0] MOVE_STATUS = 8'h00;
    logic [7:0] MOVE_DX = 8'h00;
    logic [7:0] MOVE_DY = 8'h00;
    logic       MOVE_VALID = 1'b0;
    logic       MOVE_READY;
    logic       STREAM_EN;

    mouse_device_sm dut (
        .CLK(CLK), .RESET(RESET),
        .BYTE_READY(BYTE_READY), .BYTE_READ(BYTE_READ), .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
        .READ_ENABLE(READ_ENABLE), .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND),
        .BYTE_SENT(BYTE_SENT),
        .MOVE_STATUS(MOVE_STATUS), .MOVE_DX(MOVE_DX), .MOVE_DY(MOVE_DY),
        .MOVE_VALID(MOVE_VALID), .MOVE_READY(MOVE_READY), .STREAM_EN(STREAM_EN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]      cmd;
        logic [1:0]      err;
        int              n;
        logic [0:2][7:0] rsp;
        logic            stream;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic host(input logic [7:0] b, input logic [1:0] e);
        BYTE_READ       = b;
        BYTE_ERROR_CODE = e;
        BYTE_READY      = 1'b1;
        @(negedge CLK);
        BYTE_READY      = 1'b0;
        BYTE_ERROR_CODE = 2'b00;
    endtask

    task automatic offer(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy);
        MOVE_STATUS = s;
        MOVE_DX     = dx;
        MOVE_DY     = dy;
        MOVE_VALID  = 1'b1;
        check("move_ready idle", MOVE_READY, 1);
        @(negedge CLK);
        MOVE_VALID = 1'b0;
        check("move_ready busy", MOVE_READY, 0);
    endtask

    // Waits for a SEND_BYTE pulse, checks the byte and pulse width, then acks it if asked.
    task automatic get_byte(input string name, input logic [7:0] exp, input int limit,
                            input bit ack, output int lat);
        lat = 1;
        while (!SEND_BYTE && lat < limit) begin
            @(negedge CLK);
            lat++;
        end
        check({name, " send"}, SEND_BYTE, 1);
        if (!SEND_BYTE) return;
        check(name, BYTE_TO_SEND, exp);
        @(negedge CLK);
        check({name, " pulse"}, SEND_BYTE, 0);
        check({name, " rx off"}, READ_ENABLE, 0);
        if (ack) begin
            BYTE_SENT = 1'b1;
            @(negedge CLK);
            BYTE_SENT = 1'b0;
        end
    endtask

    task automatic quiet(input string name, input int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(negedge CLK);
            if (SEND_BYTE) seen++;
        end
        check(name, seen, 0);
    endtask

    vec_t vecs [7];
    int   lat;

    initial begin
        vecs[0] = '{cmd: 8'hF4, err: 2'b00, n: 1, rsp: {8'hFA, 8'h00, 8'h00}, stream: 1'b1};
        vecs[1] = '{cmd: 8'hF2, err: 2'b00, n: 2, rsp: {8'hFA, 8'h00, 8'h00}, stream: 1'b1};
        vecs[2] = '{cmd: 8'hE6, err: 2'b00, n: 1, rsp: {8'hFA, 8'h00, 8'h00}, stream: 1'b1};
        vecs[3] = '{cmd: 8'hF4, err: 2'b01, n: 1, rsp: {8'hFE, 8'h00, 8'h00}, stream: 1'b1};
        vecs[4] = '{cmd: 8'hF5, err: 2'b00, n: 1, rsp: {8'hFA, 8'h00, 8'h00}, stream: 1'b0};
        vecs[5] = '{cmd: 8'hF3, err: 2'b10, n: 1, rsp: {8'hFE, 8'h00, 8'h00}, stream: 1'b0};
`ifdef MOUSE_DEV_RESEND_EN
        vecs[6] = '{cmd: 8'hFE, err: 2'b00, n: 1, rsp: {8'hFE, 8'h00, 8'h00}, stream: 1'b0};
`else
        vecs[6] = '{cmd: 8'hFE, err: 2'b00, n: 1, rsp: {8'hFA, 8'h00, 8'h00}, stream: 1'b0};
`endif

        repeat (3) @(negedge CLK);
        check("rst send_byte", SEND_BYTE, 0);
        check("rst byte_to_send", BYTE_TO_SEND, 8'h00);
        check("rst move_ready", MOVE_READY, 0);
        check("rst stream_en", STREAM_EN, 0);
        RESET = 1'b1;
        @(negedge CLK);
        check("rst read_enable", READ_ENABLE, 1);
        quiet("rst silent", 5);

        foreach (vecs[i]) begin
            host(vecs[i].cmd, vecs[i].err);
            for (int j = 0; j < vecs[i].n; j++) begin
                get_byte($sformatf("vec%0d byte%0d", i, j), vecs[i].rsp[j], 20, 1'b1, lat);
                if (j == 0) check($sformatf("vec%0d latency", i), lat, 2);
            end
            check($sformatf("vec%0d stream_en", i), STREAM_EN, vecs[i].stream);
            quiet($sformatf("vec%0d no extra", i), 5);
        end

        // Self-test: stream on, FF clears it and produces FA, delay, AA, 00.
        host(8'hF4, 2'b00);
        get_byte("f4 ack", 8'hFA, 20, 1'b1, lat);
        host(8'hFF, 2'b00);
        get_byte("ff ack", 8'hFA, 20, 1'b1, lat);
        check("bat rx on", READ_ENABLE, 1);
        get_byte("bat AA", 8'hAA, 1100, 1'b1, lat);
        check("bat delay window", (lat >= 1000 && lat <= 1003), 1);
        get_byte("bat 00", 8'h00, 20, 1'b1, lat);
        check("bat stream_en", STREAM_EN, 0);
        quiet("bat no extra", 5);

        // Host byte during BAT_WAIT aborts the self-test bytes.
        host(8'hFF, 2'b00);
        get_byte("abort ff ack", 8'hFA, 20, 1'b1, lat);
        repeat (50) @(negedge CLK);
        host(8'hF4, 2'b00);
        get_byte("abort f4 ack", 8'hFA, 20, 1'b1, lat);
        check("abort latency", lat, 2);
        check("abort stream_en", STREAM_EN, 1);
        quiet("abort no AA", 1100);

        // Movement packets while streaming.
        offer(8'h00, 8'h11, 8'h22);
        get_byte("pkt0 status", 8'h08, 20, 1'b1, lat);
        check("pkt0 latency", lat, 2);
        get_byte("pkt0 dx", 8'h11, 20, 1'b1, lat);
        get_byte("pkt0 dy", 8'h22, 20, 1'b1, lat);
        offer(8'h08, 8'h05, 8'hFB);
        get_byte("pkt1 status", 8'h08, 20, 1'b1, lat);
        get_byte("pkt1 dx", 8'h05, 20, 1'b1, lat);
        get_byte("pkt1 dy", 8'hFB, 20, 1'b1, lat);
        check("pkt stream_en", STREAM_EN, 1);
        host(8'hFE, 2'b00);
`ifdef MOUSE_DEV_RESEND_EN
        get_byte("resend", 8'hFB, 20, 1'b1, lat);
`else
        get_byte("resend", 8'hFA, 20, 1'b1, lat);
`endif
        quiet("resend no extra", 5);

        // Command and packet in the same cycle: command wins.
        MOVE_STATUS = 8'h01; MOVE_DX = 8'h02; MOVE_DY = 8'h03;
        MOVE_VALID      = 1'b1;
        BYTE_READ       = 8'hF2;
        BYTE_ERROR_CODE = 2'b00;
        BYTE_READY      = 1'b1;
        #1 check("collide move_ready", MOVE_READY, 0);
        @(negedge CLK);
        BYTE_READY = 1'b0;
        MOVE_VALID = 1'b0;
        get_byte("collide fa", 8'hFA, 20, 1'b1, lat);
        get_byte("collide 00", 8'h00, 20, 1'b1, lat);
        quiet("collide no packet", 10);

        // Streaming off: packets are refused.
        host(8'hF5, 2'b00);
        get_byte("f5 ack", 8'hFA, 20, 1'b1, lat);
        MOVE_VALID = 1'b1;
        repeat (5) @(negedge CLK);
        check("stream off move_ready", MOVE_READY, 0);
        quiet("stream off silent", 5);
        MOVE_VALID = 1'b0;

        // Host byte during transmission is ignored.
        host(8'hF2, 2'b00);
        host(8'hF4, 2'b00);
        get_byte("busy fa", 8'hFA, 20, 1'b1, lat);
        get_byte("busy 00", 8'h00, 20, 1'b1, lat);
        quiet("busy ignored", 10);
        check("busy stream_en", STREAM_EN, 0);

        // Reset while DX is in flight drops DY.
        host(8'hF4, 2'b00);
        get_byte("rst f4 ack", 8'hFA, 20, 1'b1, lat);
        offer(8'h08, 8'h05, 8'hFB);
        get_byte("rst status", 8'h08, 20, 1'b1, lat);
        get_byte("rst dx", 8'h05, 20, 1'b0, lat);
        RESET = 1'b0;
        #1;
        check("midrst send_byte", SEND_BYTE, 0);
        check("midrst byte_to_send", BYTE_TO_SEND, 8'h00);
        check("midrst move_ready", MOVE_READY, 0);
        check("midrst stream_en", STREAM_EN, 0);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check("midrst read_enable", READ_ENABLE, 1);
        quiet("midrst no DY", 30);
        check("midrst byte_to_send after", BYTE_TO_SEND, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
